// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: types and sizes shared by the CDB, ROB, RS and the CDB
// arbiter.
//   FU_NUM    - number of functional units (holding registers, select bits)
//   ROB_TAG_W - ROB tag width carried in RESULT, matches the CDB tag width
//   PTR_W     - width of a round-robin pointer over FU_NUM entries
//   RESULT    - {value[`XLEN-1:0], ROB_tag[ROB_TAG_W-1:0]}
`ifndef XLEN
`define XLEN 32
`endif

package cdb_arbiter_pkg;

    localparam int FU_NUM    = 5;
    localparam int ROB_TAG_W = FU_NUM + 1;
    localparam int PTR_W     = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    typedef struct packed {
        logic [`XLEN-1:0]     value;
        logic [ROB_TAG_W-1:0] ROB_tag;
    } RESULT;

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU-to-CDB result bundle between the functional units and
// the arbiter.
//   flush         - discard every held result this cycle
//   fu_valid      - per-FU result valid
//   fu_results    - per-FU result
//   fu_ready      - per-FU accept (combinational)
//   select_flag   - a grant is present this cycle
//   select_signal - one-hot grant, zero when select_flag=0
//   out_results   - held results, feeds CDB in_results
// master: FU / pipeline side.  slave: the arbiter.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                 flush;
    logic [FU_NUM-1:0]    fu_valid;
    RESULT [FU_NUM-1:0]   fu_results;
    logic [FU_NUM-1:0]    fu_ready;
    logic                 select_flag;
    logic [FU_NUM-1:0]    select_signal;
    RESULT [FU_NUM-1:0]   out_results;

    modport master (
        output flush, fu_valid, fu_results,
        input  fu_ready, select_flag, select_signal, out_results
    );

    modport slave (
        input  flush, fu_valid, fu_results,
        output fu_ready, select_flag, select_signal, out_results
    );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req       - request vector [N]
//   ptr       - index holding highest priority this cycle
//   gnt       - one-hot grant, zero if no request
//   gnt_valid - any request granted
//   gnt_idx   - binary index of the granted request
module rr_picker #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        int idx;
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        // Walk ptr, ptr+1, ... wrapping at N; the first request seen wins.
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one holding register per FU, round-robin grant of at most one
// held result per cycle onto the CDB, per-FU back-pressure, flush discard.
//   clock, reset_n - clock, asynchronous active-low reset
//   bus            - cdb_arbiter_if.slave (flush, FU inputs, CDB outputs)
// Optional (macro CDB_ARB_PERF_CNT_EN):
//   perf_grant_cnt - cycles with select_flag=1
//   perf_stall_cnt - cycles in which some FU is valid but not ready
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    cdb_arbiter_if.slave  bus
`ifdef CDB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_grant_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    logic [FU_NUM-1:0]  held_valid;
    RESULT [FU_NUM-1:0] held;
    logic [PTR_W-1:0]   rr_ptr;

    logic [FU_NUM-1:0]  gnt;
    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;
    logic [FU_NUM-1:0]  granted;
    logic [FU_NUM-1:0]  capture;

    rr_picker #(.N(FU_NUM), .PW(PTR_W)) u_pick (
        .req       (held_valid),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Flush suppresses the grant so no wrong-path result reaches the CDB.
    assign granted           = bus.flush ? '0 : gnt;
    assign bus.select_flag   = gnt_valid & ~bus.flush;
    assign bus.select_signal = granted;

    // A slot being drained this cycle can take a new result at the same edge.
    // Under flush every FU is told it was accepted; the data is then dropped.
    assign bus.fu_ready    = bus.flush ? '1 : (~held_valid | granted);
    assign capture         = bus.fu_valid & bus.fu_ready & {FU_NUM{~bus.flush}};
    assign bus.out_results = held;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held_valid <= '0;
            held       <= '0;
            rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (bus.flush)
                    held_valid[i] <= 1'b0;
                else if (capture[i])
                    held_valid[i] <= 1'b1;
                else if (granted[i])
                    held_valid[i] <= 1'b0;
                if (capture[i])
                    held[i] <= bus.fu_results[i];
            end
            if (bus.select_flag)
                rr_ptr <= (gnt_idx == PTR_W'(FU_NUM - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

`ifdef CDB_ARB_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (bus.select_flag)
                perf_grant_cnt <= perf_grant_cnt + 32'd1;
            if (|(bus.fu_valid & ~bus.fu_ready))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed + random stimulus for cdb_arbiter against a
// behavioural model of the holding slots, rotation pointer and FU sources.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    cdb_arbiter_if bus();

`ifdef CDB_ARB_PERF_CNT_EN
    logic [31:0] pg, ps;
`endif

    cdb_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef CDB_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt (pg),
        .perf_stall_cnt (ps)
`endif
    );

    int total = 0;
    int bad   = 0;

    // model state: slot occupancy/content, priority index, FU-side sources
    bit     mv[FU_NUM];
    RESULT  mheld[FU_NUM];
    int     mptr;
    bit     sv[FU_NUM];
    RESULT  sres[FU_NUM];
    bit     sflush;
    longint mgrants, mstalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.flush = sflush;
        for (int i = 0; i < FU_NUM; i++) begin
            bus.fu_valid[i]   = sv[i];
            bus.fu_results[i] = sres[i];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < FU_NUM; i++) begin
            mv[i] = 0; mheld[i] = '0; sv[i] = 0; sres[i] = '0;
        end
        mptr = 0; sflush = 0; mgrants = 0; mstalls = 0;
    endtask

    // Reset asserted mid-cycle; outputs must go idle without waiting for a clock.
    task automatic do_reset();
        @(posedge clock);
        #3;
        model_clear();
        drive();
        reset_n = 1'b0;
        #1;
        chk("rst_flag", 64'(bus.select_flag), 64'd0);
        chk("rst_sel", 64'(bus.select_signal), 64'd0);
        chk("rst_ready", 64'(bus.fu_ready), 64'h1f);
        for (int i = 0; i < FU_NUM; i++)
            chk("rst_out", 64'(bus.out_results[i]), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // new FU results appear on idle sources with probability pct%
    task automatic gen(input int pct);
        for (int i = 0; i < FU_NUM; i++)
            if (!sv[i] && $urandom_range(99) < pct) begin
                sv[i] = 1;
                sres[i].value   = $urandom;
                sres[i].ROB_tag = ROB_TAG_W'($urandom);
            end
    endtask

    // One clock: drive, compare at negedge, then advance the model at posedge.
    task automatic cycle(output int g);
        logic [FU_NUM-1:0] er, es;
        bit stall;
        drive();
        @(negedge clock);
        g = -1;
        if (!sflush)
            for (int k = 0; k < FU_NUM; k++) begin
                int i;
                i = (mptr + k) % FU_NUM;
                if (g < 0 && mv[i]) g = i;
            end
        es = '0;
        if (g >= 0) es[g] = 1'b1;
        stall = 0;
        for (int i = 0; i < FU_NUM; i++) begin
            er[i] = sflush || !mv[i] || (i == g);
            if (sv[i] && !er[i]) stall = 1;
        end
        chk("select_flag", 64'(bus.select_flag), 64'(g >= 0));
        chk("select_signal", 64'(bus.select_signal), 64'(es));
        chk("fu_ready", 64'(bus.fu_ready), 64'(er));
        for (int i = 0; i < FU_NUM; i++)
            if (mv[i]) chk("out_results", 64'(bus.out_results[i]), 64'(mheld[i]));
        @(posedge clock);
        if (g >= 0) mgrants++;
        if (stall) mstalls++;
        if (sflush) begin
            for (int i = 0; i < FU_NUM; i++) mv[i] = 0;
        end else begin
            if (g >= 0) begin
                mv[g] = 0;
                mptr  = (g + 1) % FU_NUM;
            end
            for (int i = 0; i < FU_NUM; i++)
                if (sv[i] && er[i]) begin
                    mv[i] = 1; mheld[i] = sres[i];
                end
        end
        for (int i = 0; i < FU_NUM; i++)
            if (sv[i] && er[i]) sv[i] = 0;
        sflush = 0;
        #1;
    endtask

    task automatic drain();
        int  g, n;
        bit  busy;
        n = 0;
        busy = 1;
        while (busy && n < 20) begin
            busy = 0;
            for (int i = 0; i < FU_NUM; i++) if (mv[i] || sv[i]) busy = 1;
            if (busy) begin cycle(g); n++; end
        end
        if (busy) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int g;
        model_clear();
        drive();
        do_reset();

        // idle: nothing should ever be granted
        for (int k = 0; k < 4; k++) cycle(g);

        // single result on FU2
        sv[2] = 1; sres[2].value = 32'hDEAD_BEEF; sres[2].ROB_tag = ROB_TAG_W'(3);
        cycle(g);
        drive(); #1;
        chk("single_sel", 64'(bus.select_signal), 64'b00100);
        chk("single_val", 64'(bus.out_results[2].value), 64'hDEAD_BEEF);
        chk("single_tag", 64'(bus.out_results[2].ROB_tag), 64'd3);
        cycle(g);
        drive(); #1;
        chk("single_done", 64'(bus.select_flag), 64'd0);

        // every FU saturating: strict rotation, one accept per FU per 5 cycles
        for (int k = 0; k < 15; k++) begin gen(100); cycle(g); end
        drain();

        // back-pressure: all slots full, FU1 retries with a new result
        for (int i = 0; i < FU_NUM; i++) begin
            sv[i] = 1; sres[i].value = 32'h100 + i; sres[i].ROB_tag = ROB_TAG_W'(i);
        end
        cycle(g);
        sv[1] = 1; sres[1].value = 32'h0BAD_F00D; sres[1].ROB_tag = ROB_TAG_W'(9);
        for (int k = 0; k < 8; k++) cycle(g);
        drain();

        // flush: slots 0 and 3 held, FU4 presenting
        sv[0] = 1; sres[0].value = 32'hAAAA; sres[0].ROB_tag = ROB_TAG_W'(1);
        sv[3] = 1; sres[3].value = 32'hBBBB; sres[3].ROB_tag = ROB_TAG_W'(2);
        cycle(g);
        sv[4] = 1; sres[4].value = 32'hCCCC; sres[4].ROB_tag = ROB_TAG_W'(4);
        sflush = 1;
        drive(); #1;
        chk("flush_flag", 64'(bus.select_flag), 64'd0);
        chk("flush_ready", 64'(bus.fu_ready), 64'h1f);
        cycle(g);
        drive(); #1;
        chk("flush_empty", 64'(bus.select_flag), 64'd0);
        for (int k = 0; k < 2; k++) cycle(g);
        for (int k = 0; k < 6; k++) begin gen(100); cycle(g); end
        drain();

        // grant and refill of slot 2 in the same cycle
        sv[2] = 1; sres[2].value = 32'h55; sres[2].ROB_tag = ROB_TAG_W'(5);
        cycle(g);
        sv[2] = 1; sres[2].value = 32'h77; sres[2].ROB_tag = ROB_TAG_W'(7);
        drive(); #1;
        chk("refill_ready", 64'(bus.fu_ready[2]), 64'd1);
        cycle(g);
        drive(); #1;
        chk("refill_sel", 64'(bus.select_signal), 64'b00100);
        chk("refill_tag", 64'(bus.out_results[2].ROB_tag), 64'd7);
        cycle(g);
        sv[0] = 1; sv[2] = 1; sv[3] = 1; sv[4] = 1;
        cycle(g);
        drive(); #1;
        chk("refill_ptr", 64'(bus.select_signal), 64'b01000);
        drain();

        // random traffic with occasional flushes and one mid-run reset
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            gen(40);
            sflush = ($urandom_range(99) < 4);
            cycle(g);
        end

`ifdef CDB_ARB_PERF_CNT_EN
        chk("perf_grant", 64'(pg), 64'(mgrants[31:0]));
        chk("perf_stall", 64'(ps), 64'(mstalls[31:0]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
